// File: rtl/mul_seq_xnym_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_seq_xnym_pkg;

  localparam int X_WIDTH_DEF = 8;
  localparam int Y_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_FIX  = 2'd2
  } ms_state_e;

  // Counter must hold 0..Y_WIDTH.
  function automatic int cnt_width(input int yw);
    return $clog2(yw + 1);
  endfunction

endpackage

// File: rtl/mul_seq_xnym_twos_cond_neg.sv
// Conditional two's-complement negation: o = neg ? -a : a.
// Purely combinational, no backpressure.
module twos_cond_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] o
);

  always_comb begin
    o = neg ? (~a + 1'b1) : a;
  end

endmodule

// File: rtl/mul_seq_xnym.sv
// Sequential shift-add multiplier, X_WIDTH x Y_WIDTH, signed or unsigned per operation.
// Latency Y_WIDTH+1 edges from accepted start to valid; start is ignored while rdy=0.
module mul_seq_xnym
  import mul_seq_xnym_pkg::*;
#(
  parameter  int X_WIDTH = X_WIDTH_DEF,
  parameter  int Y_WIDTH = Y_WIDTH_DEF,
  localparam int P_WIDTH = X_WIDTH + Y_WIDTH
) (
`ifdef GL_TEST
  inout  wire                vccd1,
  inout  wire                vssd1,
`endif
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] p,
  output logic               s,
  output logic               valid,
  output logic               rdy
);

  localparam int CNT_W = cnt_width(Y_WIDTH);

  ms_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [P_WIDTH-1:0]  acc_q, acc_d;
  logic [P_WIDTH-1:0]  mcand_q, mcand_d;
  logic [Y_WIDTH-1:0]  mplier_q, mplier_d;
  logic                neg_q, neg_d;
  logic                sgn_q, sgn_d;
  logic [P_WIDTH-1:0]  p_q, p_d;
  logic                s_q, s_d;
  logic                valid_q, valid_d;

  logic [X_WIDTH-1:0]  x_abs;
  logic [Y_WIDTH-1:0]  y_abs;
  logic [P_WIDTH-1:0]  prod_fix;

  // Magnitudes are taken from the live inputs and only used in the start cycle.
  twos_cond_neg #(.W(X_WIDTH)) u_abs_x (.a(x), .neg(sgn & x[X_WIDTH-1]), .o(x_abs));
  twos_cond_neg #(.W(Y_WIDTH)) u_abs_y (.a(y), .neg(sgn & y[Y_WIDTH-1]), .o(y_abs));
  twos_cond_neg #(.W(P_WIDTH)) u_fix   (.a(acc_q), .neg(neg_q), .o(prod_fix));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    p_d      = p_q;
    s_d      = s_q;
    valid_d  = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (start) begin
          sgn_d    = sgn;
          neg_d    = sgn & (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = {{Y_WIDTH{1'b0}}, x_abs};
          mplier_d = y_abs;
          state_d  = MS_RUN;
        end
      end
      MS_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(Y_WIDTH - 1)) state_d = MS_FIX;
      end
      MS_FIX: begin
        p_d     = prod_fix;
        s_d     = sgn_q & prod_fix[P_WIDTH-1];
        valid_d = 1'b1;
        state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MS_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      p_q      <= '0;
      s_q      <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      p_q      <= p_d;
      s_q      <= s_d;
      valid_q  <= valid_d;
    end
  end

  assign p     = p_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign rdy   = (state_q == MS_IDLE);

endmodule

// File: tb/tb_mul_seq_xnym.sv
// Bench for mul_seq_xnym: arithmetic reference model checked every cycle plus directed literals.
module tb_mul_seq_xnym;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 instance
  logic        rst, start, sgn;
  logic [7:0]  x, y;
  logic [15:0] p;
  logic        s, valid, rdy;

  // 4x2 instance
  logic        start_b, sgn_b;
  logic [3:0]  x_b;
  logic [1:0]  y_b;
  logic [5:0]  p_b;
  logic        s_b, valid_b, rdy_b;

  mul_seq_xnym #(.X_WIDTH(8), .Y_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .x(x), .y(y),
    .p(p), .s(s), .valid(valid), .rdy(rdy)
  );

  mul_seq_xnym #(.X_WIDTH(4), .Y_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sgn(sgn_b), .x(x_b), .y(y_b),
    .p(p_b), .s(s_b), .valid(valid_b), .rdy(rdy_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: cycles remaining until the result appears.
  int          m_busy = 0;
  logic [15:0] m_p = '0, m_pend_p = '0;
  logic        m_s = 1'b0, m_pend_s = 1'b0, m_valid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic sg, input logic [7:0] a, input logic [7:0] b);
    longint av, bv, pr;
    av = sg ? longint'($signed(a)) : longint'(a);
    bv = sg ? longint'($signed(b)) : longint'(b);
    pr = av * bv;
    return pr[15:0];
  endfunction

  task automatic model_step();
    logic [15:0] r;
    if (rst) begin
      m_busy = 0; m_p = '0; m_s = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_p = m_pend_p; m_s = m_pend_s; m_valid = 1'b1;
        end
      end else if (start) begin
        r        = ref_mul(sgn, x, y);
        m_pend_p = r;
        m_pend_s = sgn & r[15];
        m_busy   = 9;
      end
    end
  endtask

  task automatic compare();
    chk("rdy",   {63'd0, rdy},   {63'd0, (m_busy == 0)});
    chk("valid", {63'd0, valid}, {63'd0, m_valid});
    chk("p",     {48'd0, p},     {48'd0, m_p});
    chk("s",     {63'd0, s},     {63'd0, m_s});
  endtask

  // Every clock advance goes through here: model at the edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run_op(input logic sg, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input logic exp_s, input string nm);
    int k;
    start = 1'b1; sgn = sg; x = a; y = b;
    tick();
    start = 1'b0; sgn = ~sg; x = ~a; y = ~b;
    k = 0;
    while (!valid && k < 20) begin tick(); k++; end
    chk({nm, "_latency"}, 64'(k), 64'd9);
    chk({nm, "_p"}, {48'd0, p}, {48'd0, exp_p});
    chk({nm, "_s"}, {63'd0, s}, {63'd0, exp_s});
  endtask

  task automatic run_b(input logic sg, input logic [3:0] a, input logic [1:0] b,
                       input logic [5:0] exp_p, input logic exp_s, input string nm);
    int k;
    start_b = 1'b1; sgn_b = sg; x_b = a; y_b = b;
    tick();
    start_b = 1'b0; x_b = ~a; y_b = ~b;
    k = 0;
    while (!valid_b && k < 10) begin tick(); k++; end
    chk({nm, "_latency"}, 64'(k), 64'd3);
    chk({nm, "_p"}, {58'd0, p_b}, {58'd0, exp_p});
    chk({nm, "_s"}, {63'd0, s_b}, {63'd0, exp_s});
  endtask

  initial begin
    int k, nv;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; x = '0; y = '0;
    start_b = 1'b0; sgn_b = 1'b0; x_b = '0; y_b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_p",     {48'd0, p},      64'd0);
    chk("reset_rdy",   {63'd0, rdy},    64'd1);
    chk("reset_valid", {63'd0, valid},  64'd0);
    chk("reset_b_rdy", {63'd0, rdy_b},  64'd1);

    run_op(1'b0, 8'd255, 8'd255, 16'hFE01, 1'b0, "u255x255");
    run_op(1'b1, 8'h80,  8'h80,  16'h4000, 1'b0, "s_m128xm128");
    run_op(1'b1, 8'hFD,  8'd5,   16'hFFF1, 1'b1, "s_m3x5");
    run_op(1'b1, 8'd0,   8'hF9,  16'h0000, 1'b0, "s_0xm7");
    // Accepted in the valid cycle of the previous result.
    run_op(1'b0, 8'd3,   8'd4,   16'd12,   1'b0, "b2b_3x4");
    run_op(1'b0, 8'd10,  8'd10,  16'd100,  1'b0, "b2b_10x10");

    // Start pulse while busy must be dropped.
    tick();
    start = 1'b1; sgn = 1'b0; x = 8'd7; y = 8'd6;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; x = 8'd2; y = 8'd2;
    tick();
    start = 1'b0;
    k = 3;
    while (!valid && k < 20) begin tick(); k++; end
    chk("busy_start_latency", 64'(k), 64'd9);
    chk("busy_start_p", {48'd0, p}, 64'd42);
    nv = 0;
    repeat (12) begin tick(); if (valid) nv++; end
    chk("busy_start_no_second_valid", 64'(nv), 64'd0);

    // Reset mid-operation kills the result; restart completes normally.
    start = 1'b1; x = 8'd9; y = 8'd9;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rdy",   {63'd0, rdy},   64'd1);
    chk("midrst_p",     {48'd0, p},     64'd0);
    chk("midrst_valid", {63'd0, valid}, 64'd0);
    start = 1'b1; x = 8'd6; y = 8'd11;
    tick();
    start = 1'b0;
    k = 0;
    while (!valid && k < 20) begin tick(); k++; end
    chk("restart_latency", 64'(k), 64'd9);
    chk("restart_p", {48'd0, p}, 64'h42);

    run_b(1'b0, 4'd15, 2'd3,  6'd45,  1'b0, "b_u15x3");
    run_b(1'b1, 4'h8,  2'b10, 6'd16,  1'b0, "b_s_m8xm2");
    run_b(1'b1, 4'h8,  2'b01, 6'h38,  1'b1, "b_s_m8x1");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
